// File: rtl/sigcap_pkg.sv
// Shared types and default sizes for the sample capture/delay line.
package sigcap_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } cap_state_t;

  localparam int A_WIDTH_DEF = 9;
  localparam int D_WIDTH_DEF = 8;

endpackage

// File: rtl/sig_capture_delay_if.sv
// Sample-stream bundle between a sample source/controller and the capture delay line.
interface sig_capture_delay_if
  import sigcap_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) ();

  logic               en;
  logic [A_WIDTH-1:0] offset;
  logic [D_WIDTH-1:0] din;
  logic [D_WIDTH-1:0] dout;
  logic               dout_valid;
  logic [A_WIDTH-1:0] wr_addr;

  modport master (
    output en, offset, din,
    input  dout, dout_valid, wr_addr
  );

  modport slave (
    input  en, offset, din,
    output dout, dout_valid, wr_addr
  );

endinterface

// File: rtl/sig_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, read-before-write, no reset.
module sig_dpram #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] wa_i,
  input  logic [D_WIDTH-1:0] wd_i,
  input  logic               re_i,
  input  logic [A_WIDTH-1:0] ra_i,
  output logic [D_WIDTH-1:0] rd_o
);

  logic [D_WIDTH-1:0] mem [2**A_WIDTH];
  logic [D_WIDTH-1:0] rd_q;

  // Same-address collision returns the old word because both updates are non-blocking.
  always_ff @(posedge clk) begin
    if (we_i) mem[wa_i] <= wd_i;
    if (re_i) rd_q <= mem[ra_i];
  end

  assign rd_o = rd_q;

endmodule

// File: rtl/sig_capture_delay.sv
// Circular-buffer delay line: replays each accepted sample after `offset` accepted samples.
module sig_capture_delay
  import sigcap_pkg::*;
#(
  parameter int A_WIDTH = A_WIDTH_DEF,
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  sig_capture_delay_if.slave  bus
);

  localparam logic [A_WIDTH-1:0] ONE     = A_WIDTH'(1);
  localparam logic [A_WIDTH-1:0] CNT_MAX = '1;

  cap_state_t         state_q, state_d;
  logic [A_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [A_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [A_WIDTH-1:0] offset_q;
  logic [D_WIDTH-1:0] byp_q, byp_d;
  logic               sel_ram_q, sel_ram_d;
  logic [A_WIDTH-1:0] rd_addr;
  logic [D_WIDTH-1:0] ram_rd;
  logic               offset_chg;

  assign rd_addr    = wr_ptr_q - offset_q;
  assign offset_chg = (bus.offset != offset_q);

  sig_dpram #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we_i (bus.en),
    .wa_i (wr_ptr_q),
    .wd_i (bus.din),
    .re_i (bus.en),
    .ra_i (rd_addr),
    .rd_o (ram_rd)
  );

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    byp_d      = byp_q;
    sel_ram_d  = sel_ram_q;
    if (bus.en) begin
      wr_ptr_d  = wr_ptr_q + ONE;
      sel_ram_d = (offset_q != '0);
      if (offset_q == '0) byp_d = bus.din;
      if (fill_cnt_q != CNT_MAX) fill_cnt_d = fill_cnt_q + ONE;
      if ((state_q == FILL) && (fill_cnt_q >= offset_q)) state_d = RUN;
    end
    // A new delay invalidates everything primed so far; the sample on this edge is not counted.
    if (offset_chg) begin
      fill_cnt_d = '0;
      state_d    = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      offset_q   <= '0;
      byp_q      <= '0;
      sel_ram_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      offset_q   <= bus.offset;
      byp_q      <= byp_d;
      sel_ram_q  <= sel_ram_d;
    end
  end

  assign bus.dout       = sel_ram_q ? ram_rd : byp_q;
  assign bus.dout_valid = (state_q == RUN);
  assign bus.wr_addr    = wr_ptr_q;

endmodule
